// File: rtl/branch_hazard_sequencer.sv
// ============================================================================
//  Module   : branch_hazard_sequencer
//  Purpose  : ID-stage branch/jump stall, bubble and flush sequencing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module branch_hazard_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_branch,
    input  logic             ID_Jump,
    input  logic             ID_Use_RS1,
    input  logic             ID_Use_RS2,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             EX_Reg_RW,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RD,
    input  logic             MEM_Reg_RW,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_RD,
    input  logic             Branch_Taken,
    input  logic             Ext_Stall,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam logic [1:0]       S_RUN   = 2'd0;
    localparam logic [1:0]       S_STALL = 2'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       w_ctl;
    logic       w_match_ex;
    logic       w_match_mem;
    logic [1:0] w_depth;
    logic       w_stall_cycle;
    logic       w_resolve;
    logic       w_flush_evt;

    assign w_ctl = ID_branch | ID_Jump;

    assign w_match_ex  = w_ctl && (EX_RD != 5'd0) &&
                         ((ID_Use_RS1 && (EX_RD == ID_RS1)) ||
                          (ID_Use_RS2 && (EX_RD == ID_RS2)));
    assign w_match_mem = w_ctl && (MEM_RD != 5'd0) &&
                         ((ID_Use_RS1 && (MEM_RD == ID_RS1)) ||
                          (ID_Use_RS2 && (MEM_RD == ID_RS2)));

    // Priority order yields the deepest required stall when several producers match.
    always_comb begin
        w_depth = 2'd0;
        if (EX_Reg_RW && EX_MemRead && w_match_ex) begin
            w_depth = 2'd2;
        end else if (EX_Reg_RW && w_match_ex) begin
            w_depth = 2'd1;
        end else if (MEM_Reg_RW && MEM_MemRead && w_match_mem) begin
            w_depth = 2'd1;
        end
    end

    assign w_stall_cycle = !Ext_Stall &&
                           (((state_q == S_RUN) && (w_depth != 2'd0)) ||
                            ((state_q == S_STALL) && (cnt_q != 2'd0)));
    assign w_resolve     = !Ext_Stall && !w_stall_cycle;
    assign w_flush_evt   = w_resolve && w_ctl && (ID_Jump || Branch_Taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!Ext_Stall) begin
            case (state_q)
                S_RUN: begin
                    if (w_depth != 2'd0) begin
                        state_d = S_STALL;
                        cnt_d   = w_depth - 2'd1;
                    end
                end
                S_STALL: begin
                    if (cnt_q != 2'd0) begin
                        cnt_d = cnt_q - 2'd1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
            if (w_stall_cycle && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (w_flush_evt && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    // Control outputs are forced low for the whole reset pulse, not just at the edge.
    always_comb begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (!rst) begin
            if (w_stall_cycle) begin
                IDEX_Bubble = 1'b1;
            end else if (w_resolve) begin
                PC_Write   = 1'b1;
                IFID_Write = 1'b1;
                IFID_Flush = w_flush_evt;
            end
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_sequencer.sv
// ============================================================================
//  Module   : tb_branch_hazard_sequencer
//  Purpose  : Directed self-checking bench with a stall-budget reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_hazard_sequencer;

    localparam int CW   = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ID_branch, ID_Jump, ID_Use_RS1, ID_Use_RS2;
    logic [4:0]    ID_RS1, ID_RS2, EX_RD, MEM_RD;
    logic          EX_Reg_RW, EX_MemRead, MEM_Reg_RW, MEM_MemRead;
    logic          Branch_Taken, Ext_Stall;
    logic          PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble;
    logic [CW-1:0] Stall_Count, Flush_Count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_hazard_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_branch(ID_branch), .ID_Jump(ID_Jump),
        .ID_Use_RS1(ID_Use_RS1), .ID_Use_RS2(ID_Use_RS2),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .EX_Reg_RW(EX_Reg_RW), .EX_MemRead(EX_MemRead), .EX_RD(EX_RD),
        .MEM_Reg_RW(MEM_Reg_RW), .MEM_MemRead(MEM_MemRead), .MEM_RD(MEM_RD),
        .Branch_Taken(Branch_Taken), .Ext_Stall(Ext_Stall),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a branch in ID owes a stall budget fixed on arrival;
    // it is paid one cycle at a time, then the branch resolves.
    bit m_busy, n_busy;
    int m_need, n_need, m_done, n_done;
    int m_sc, n_sc, m_fc, n_fc;

    function automatic bit hits(input logic [4:0] rd);
        return (rd != 0) && ((ID_Use_RS1 && rd == ID_RS1) || (ID_Use_RS2 && rd == ID_RS2));
    endfunction

    function automatic int need_now();
        int n = 0;
        if (!(ID_branch || ID_Jump)) return 0;
        if (EX_Reg_RW && hits(EX_RD)) n = EX_MemRead ? 2 : 1;
        if (MEM_Reg_RW && MEM_MemRead && hits(MEM_RD) && n < 1) n = 1;
        return n;
    endfunction

    always @(negedge clk) begin
        bit e_pc, e_bub, e_fl;
        int need, done;
        e_pc = 0; e_bub = 0; e_fl = 0;
        n_busy = m_busy; n_need = m_need; n_done = m_done; n_sc = m_sc; n_fc = m_fc;
        if (rst) begin
            m_busy = 0; m_need = 0; m_done = 0; m_sc = 0; m_fc = 0;
            n_busy = 0; n_need = 0; n_done = 0; n_sc = 0; n_fc = 0;
        end else if (!Ext_Stall) begin
            need = m_busy ? m_need : need_now();
            done = m_busy ? m_done : 0;
            if (done < need) begin
                e_bub  = 1;
                n_busy = 1; n_need = need; n_done = done + 1;
                n_sc   = (m_sc < MAXV) ? m_sc + 1 : m_sc;
            end else begin
                e_pc   = 1;
                e_fl   = (ID_branch || ID_Jump) && (ID_Jump || Branch_Taken);
                n_busy = 0; n_need = 0; n_done = 0;
                if (e_fl) n_fc = (m_fc < MAXV) ? m_fc + 1 : m_fc;
            end
        end
        check("cyc_PC_Write",    PC_Write,    e_pc);
        check("cyc_IFID_Write",  IFID_Write,  e_pc);
        check("cyc_IDEX_Bubble", IDEX_Bubble, e_bub);
        check("cyc_IFID_Flush",  IFID_Flush,  e_fl);
        check("cyc_Stall_Count", Stall_Count, m_sc);
        check("cyc_Flush_Count", Flush_Count, m_fc);
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = n_busy; m_need = n_need; m_done = n_done; m_sc = n_sc; m_fc = n_fc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_branch = 0; ID_Jump = 0; ID_Use_RS1 = 0; ID_Use_RS2 = 0;
        ID_RS1 = 0; ID_RS2 = 0; EX_Reg_RW = 0; EX_MemRead = 0; EX_RD = 0;
        MEM_Reg_RW = 0; MEM_MemRead = 0; MEM_RD = 0; Branch_Taken = 0; Ext_Stall = 0;
    endtask

    task automatic set_id(input bit br, input bit j, input bit u1, input bit u2,
                          input logic [4:0] r1, input logic [4:0] r2, input bit tk);
        ID_branch = br; ID_Jump = j; ID_Use_RS1 = u1; ID_Use_RS2 = u2;
        ID_RS1 = r1; ID_RS2 = r2; Branch_Taken = tk;
    endtask

    task automatic set_prod(input bit erw, input bit emr, input logic [4:0] erd,
                            input bit mrw, input bit mmr, input logic [4:0] mrd);
        EX_Reg_RW = erw; EX_MemRead = emr; EX_RD = erd;
        MEM_Reg_RW = mrw; MEM_MemRead = mmr; MEM_RD = mrd;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic chk_stall(input string tag);
        #1;
        check({tag, "_pc"},  PC_Write,    1'b0);
        check({tag, "_bub"}, IDEX_Bubble, 1'b1);
    endtask

    task automatic chk_resolve(input string tag, input bit fl);
        #1;
        check({tag, "_pc"},    PC_Write,    1'b1);
        check({tag, "_bub"},   IDEX_Bubble, 1'b0);
        check({tag, "_flush"}, IFID_Flush,  fl);
    endtask

    initial begin
        clear_inputs();
        #2;
        check("rst_pc",  PC_Write,    1'b0);
        check("rst_sc",  Stall_Count, 0);
        check("rst_fc",  Flush_Count, 0);
        do_reset();

        // BEQ x5,x6 against EX ALU writer of x5, taken
        set_id(1, 0, 1, 1, 5'd5, 5'd6, 1); set_prod(1, 0, 5'd5, 0, 0, 5'd0);
        chk_stall("s1_stall");
        step(); chk_resolve("s1_res", 1);
        step(); clear_inputs(); #1;
        check("s1_sc", Stall_Count, 1); check("s1_fc", Flush_Count, 1);

        // BNE x7,x0 against EX load of x7, not taken
        do_reset();
        set_id(1, 0, 1, 1, 5'd7, 5'd0, 0); set_prod(1, 1, 5'd7, 0, 0, 5'd0);
        chk_stall("s2_st1"); step(); chk_stall("s2_st2");
        step(); chk_resolve("s2_res", 0);
        step(); clear_inputs(); #1;
        check("s2_sc", Stall_Count, 2); check("s2_fc", Flush_Count, 0);

        // JALR rs1=3 against MEM load of x3
        do_reset();
        set_id(0, 1, 1, 0, 5'd3, 5'd0, 0); set_prod(0, 0, 5'd0, 1, 1, 5'd3);
        chk_stall("s3_stall"); step(); chk_resolve("s3_res", 1);
        step(); clear_inputs(); #1;
        check("s3_sc", Stall_Count, 1); check("s3_fc", Flush_Count, 1);

        // BEQ x4,x9: EX ALU x4 + MEM load x9 -> 1, EX load x4 -> 2
        do_reset();
        set_id(1, 0, 1, 1, 5'd4, 5'd9, 0); set_prod(1, 0, 5'd4, 1, 1, 5'd9);
        chk_stall("s4a_stall"); step(); chk_resolve("s4a_res", 0);
        step(); clear_inputs(); #1;
        check("s4a_sc", Stall_Count, 1);
        do_reset();
        set_id(1, 0, 1, 1, 5'd4, 5'd9, 0); set_prod(1, 1, 5'd4, 1, 0, 5'd9);
        chk_stall("s4b_st1"); step(); chk_stall("s4b_st2");
        step(); chk_resolve("s4b_res", 0);
        step(); clear_inputs(); #1;
        check("s4b_sc", Stall_Count, 2);

        // Ext_Stall for 3 cycles inside a 2-cycle load stall
        do_reset();
        set_id(1, 0, 1, 1, 5'd7, 5'd0, 0); set_prod(1, 1, 5'd7, 0, 0, 5'd0);
        chk_stall("s5_st1"); step();
        Ext_Stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s5_frz_pc",  PC_Write,    1'b0);
            check("s5_frz_bub", IDEX_Bubble, 1'b0);
            step();
        end
        Ext_Stall = 0;
        chk_stall("s5_st2"); step(); chk_resolve("s5_res", 0);
        step(); clear_inputs(); #1;
        check("s5_sc", Stall_Count, 2);

        // Reset mid-stall, then an ADD with a matching EX writer
        do_reset();
        set_id(1, 0, 1, 1, 5'd7, 5'd0, 0); set_prod(1, 1, 5'd7, 0, 0, 5'd0);
        chk_stall("s6_st1"); step();
        rst = 1; #1;
        check("s6_rst_bub", IDEX_Bubble, 1'b0);
        check("s6_rst_pc",  PC_Write,    1'b0);
        check("s6_rst_sc",  Stall_Count, 0);
        step(); step(); rst = 0;
        set_id(0, 0, 1, 1, 5'd7, 5'd0, 0);
        chk_resolve("s6_add0", 0); step(); chk_resolve("s6_add1", 0);
        step(); #1;
        check("s6_sc", Stall_Count, 0);

        // Unused rs and x0 never create a hazard
        set_id(1, 0, 0, 1, 5'd5, 5'd6, 0); set_prod(1, 1, 5'd5, 0, 0, 5'd0);
        chk_resolve("s7_unused", 0); step();
        set_id(1, 0, 1, 1, 5'd0, 5'd0, 1); set_prod(1, 1, 5'd0, 1, 1, 5'd0);
        chk_resolve("s7_x0", 1); step();

        // Saturation: repeated jump with a 1-cycle EX hazard
        do_reset();
        set_id(0, 1, 1, 0, 5'd2, 5'd0, 0); set_prod(1, 0, 5'd2, 0, 0, 5'd0);
        for (int i = 0; i < 20; i++) step();
        clear_inputs(); step(); #1;
        check("s8_sc_sat", Stall_Count, MAXV);
        check("s8_fc_sat", Flush_Count, MAXV);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_hazard_sequencer.md
Name: branch_hazard_sequencer

Overview:
- Sequences pipeline control for ID-stage branch/jump resolution in the 5-stage RISC-V core.
- Detects data hazards on the branch comparator operands and loads a stall counter of 1 or 2 cycles.
- Holds PC and IF/ID, inserts ID/EX bubbles, and flushes IF/ID on a taken branch or a jump.
- Sits between the hazard inputs and the PC/IF/ID/ID/EX register enables. It supersedes the Stall output of branch_forward_unit; the forwarding selects stay in branch_forward_unit.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle and flush event counters.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ID_branch  input  1  conditional branch in ID
- ID_Jump  input  1  JAL/JALR in ID
- ID_Use_RS1  input  1  ID instruction reads rs1
- ID_Use_RS2  input  1  ID instruction reads rs2
- ID_RS1  input  5  rs1 index in ID
- ID_RS2  input  5  rs2 index in ID
- EX_Reg_RW  input  1  EX instruction writes rd
- EX_MemRead  input  1  EX instruction is a load
- EX_RD  input  5  EX destination
- MEM_Reg_RW  input  1  MEM instruction writes rd
- MEM_MemRead  input  1  MEM instruction is a load
- MEM_RD  input  5  MEM destination
- Branch_Taken  input  1  comparator result in ID, valid only when not stalling
- Ext_Stall  input  1  global freeze (memory wait)
- PC_Write  output  1  PC enable
- IFID_Write  output  1  IF/ID enable
- IFID_Flush  output  1  zero IF/ID on next edge
- IDEX_Bubble  output  1  force NOP into ID/EX
- Stall_Count  output  CNT_W  saturating count of hazard stall cycles
- Flush_Count  output  CNT_W  saturating count of redirects

Behaviour:
- Control instruction (ctl) = ID_branch | ID_Jump.
- Match(rd) = ctl & rd != 0 & ((ID_Use_RS1 & rd == ID_RS1) | (ID_Use_RS2 & rd == ID_RS2)).
- Required stall depth N is computed in RUN as follows:
  - EX_Reg_RW & EX_MemRead & Match(EX_RD) -> 2
  - else EX_Reg_RW & Match(EX_RD) -> 1
  - else MEM_Reg_RW & MEM_MemRead & Match(MEM_RD) -> 1
  - else 0
  - When several conditions hold, the maximum applies. This is guaranteed by the priority order above.
- State: 2-bit FSM {RUN, STALL}, plus 2-bit counter cnt.
- Reset (async): state=RUN, cnt=0, Stall_Count=0, Flush_Count=0.
- While rst is high, all control outputs are 0.
- Reset mid-stall abandons the stall; after release, hazards are re-evaluated from RUN.
- Ext_Stall=1, any state:
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0.
  - state, cnt and counters are held.
  - Ext_Stall has top priority.
- RUN, Ext_Stall=0, N>0:
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
  - Next state is STALL, with cnt=N-1.
  - Stall_Count increments.
- RUN, Ext_Stall=0, N=0:
  - PC_Write=1, IFID_Write=1, IDEX_Bubble=0.
  - IFID_Flush = ctl & (ID_Jump | Branch_Taken).
  - Flush_Count increments when IFID_Flush=1.
- STALL, Ext_Stall=0:
  - Hazard inputs are ignored.
  - If cnt>0: outputs as a stall cycle (PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0), cnt decrements, Stall_Count increments.
  - If cnt=0: outputs exactly as RUN with N=0 (the branch resolves this cycle), next state RUN.
- Total stall length is therefore exactly N cycles. Resolution occurs in cycle N+1 after the branch enters ID, not counting Ext_Stall cycles.
- Branch_Taken is never sampled during stall cycles.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Non-control instructions never stall or flush, even when indices match.
- Index 0 never creates a hazard.
- Unused rs indices never create a hazard.

Test Plan:
- BEQ x5,x6 in ID, EX_Reg_RW=1, EX_RD=5, not a load, Branch_Taken=1 -> 1 stall cycle (PC_Write=0, IDEX_Bubble=1), then PC_Write=1, IFID_Flush=1; Stall_Count=1, Flush_Count=1.
- BNE x7,x0 in ID, load in EX with EX_RD=7, Branch_Taken=0 -> exactly 2 stall cycles, then IFID_Flush=0, PC_Write=1; Stall_Count=2.
- JALR with rs1=3, load in MEM with MEM_RD=3 -> 1 stall, then IFID_Flush=1 regardless of Branch_Taken.
- EX ALU op with EX_RD=4 and MEM load with MEM_RD=9 against BEQ x4,x9 -> exactly 1 stall (maximum rule); same case with the load in EX instead -> 2 stalls.
- Ext_Stall asserted for 3 cycles during the 2-cycle load stall -> all outputs 0 for 3 cycles, cnt held; resolution arrives 5 cycles after entry; Stall_Count=2.
- rst pulsed mid-STALL -> outputs 0 immediately, counters=0, FSM in RUN; an ADD with EX_RD matching its rs never stalls.
